// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU with iterative multiply/divide:
// op codes, controller states and the op-class helper.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_CTZ   = 5'd10,
    OP_CLZ   = 5'd11,
    OP_CPOP  = 5'd12,
    OP_MUL   = 5'd16,
    OP_MULHU = 5'd17,
    OP_DIV   = 5'd18,
    OP_DIVU  = 5'd19,
    OP_REM   = 5'd20,
    OP_REMU  = 5'd21
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // Ops that run through the multi-cycle multiply/divide datapath.
  function automatic logic is_iter(input logic [4:0] op);
    return (op >= 5'd16) && (op <= 5'd21);
  endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative unsigned datapath: shift-add multiply and restoring divide,
// one bit per step, with its own step counter.
module md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             last_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;

  // hi:lo is the product register for multiply and remainder:quotient for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    if (load_i) begin
      cnt_d    = CNT_INIT;
      hi_d     = '0;
      lo_d     = a_i;
      opnd_d   = b_i;
      is_div_d = is_div_i;
    end else if (step_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
      if (is_div_q) begin
        hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], div_ge};
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign last_o = (cnt_q == CNT_ONE);

endmodule

// File: rtl/alu_md_seq.sv
// Handshaked ALU: single-cycle integer/bit-count ops plus iterative
// multiply/divide, with registered result and compare flags.
module alu_md_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             eq,
  output logic             lt,
  output logic             ltu
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q;
  logic             eq_q, lt_q, ltu_q;

  logic             accept, load, step, last;
  logic             signed_div, is_div;
  logic [WIDTH-1:0] mag_a, mag_b, hi, lo;
  logic [WIDTH-1:0] alu_res, fix_res;
  logic [WIDTH-1:0] ctz, clz, cpop;
  logic [SHW-1:0]   sh;
  logic             eq_c, lt_c, ltu_c;

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
    step     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = is_iter(op) ? CALC : DONE;
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_d = FIX;
      end
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    load = accept && is_iter(op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Signed divide runs on magnitudes; signs are restored in FIX.
  always_comb begin
    signed_div = (op == OP_DIV) || (op == OP_REM);
    is_div     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    mag_a      = (signed_div && a[WIDTH-1]) ? -a : a;
    mag_b      = (signed_div && b[WIDTH-1]) ? -b : b;
  end

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .step_i  (step),
    .is_div_i(is_div),
    .a_i     (mag_a),
    .b_i     (mag_b),
    .hi_o    (hi),
    .lo_o    (lo),
    .last_o  (last)
  );

  always_comb begin
    ctz  = WIDTH'(WIDTH);
    clz  = WIDTH'(WIDTH);
    cpop = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (a[i]) ctz = WIDTH'(i);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) clz = WIDTH'(WIDTH - 1 - i);
      cpop = cpop + WIDTH'(a[i]);
    end
  end

  always_comb begin
    sh    = b[SHW-1:0];
    eq_c  = (a == b);
    lt_c  = ($signed(a) < $signed(b));
    ltu_c = (a < b);
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $signed(a) >>> sh;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_c};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ltu_c};
      OP_CTZ:  alu_res = ctz;
      OP_CLZ:  alu_res = clz;
      OP_CPOP: alu_res = cpop;
      default: alu_res = '0;
    endcase
  end

  // Divide-by-zero results are forced here rather than trusting the datapath.
  always_comb begin
    case (op_q)
      OP_MUL:   fix_res = lo;
      OP_MULHU: fix_res = hi;
      OP_DIV, OP_DIVU: begin
        if (b_q == '0)                                          fix_res = '1;
        else if ((op_q == OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) fix_res = -lo;
        else                                                    fix_res = lo;
      end
      OP_REM, OP_REMU: begin
        if (b_q == '0)                              fix_res = a_q;
        else if ((op_q == OP_REM) && a_q[WIDTH-1])  fix_res = -hi;
        else                                        fix_res = hi;
      end
      default: fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      a_q   <= a;
      b_q   <= b;
      eq_q  <= eq_c;
      lt_q  <= lt_c;
      ltu_q <= ltu_c;
      if (!is_iter(op)) result_q <= alu_res;
    end else if (state_q == FIX) begin
      result_q <= fix_res;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;

endmodule

// File: tb/tb_alu_md_seq.sv
// Self-checking bench for alu_md_seq: directed corner cases, randomized ops
// against an arithmetic reference model, handshake and reset scenarios.
module tb_alu_md_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          eq, lt, ltu;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
  } vec_t;

  alu_md_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .eq       (eq),
    .lt       (lt),
    .ltu      (ltu)
  );

  always #5 clk = ~clk;

  function automatic logic ref_iter(input logic [4:0] o);
    return (o >= 5'd16) && (o <= 5'd21);
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy, n;
    longint unsigned p;
    sx = x;
    sy = y;
    p  = {32'b0, x} * {32'b0, y};
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x ^ y;
      5'd5:  return x << y[4:0];
      5'd6:  return x >> y[4:0];
      5'd7:  return sx >>> y[4:0];
      5'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      5'd9:  return (x < y) ? 32'd1 : 32'd0;
      5'd10: begin n = 0; while (n < 32 && !x[n]) n++; return n; end
      5'd11: begin n = 0; while (n < 32 && !x[31-n]) n++; return n; end
      5'd12: return $countones(x);
      5'd16: return p[31:0];
      5'd17: return p[63:32];
      5'd18: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return sx / sy;
      end
      5'd19: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd20: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return sx % sy;
      end
      5'd21: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    return {x == y, sx < sy, x < y};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return $urandom_range(0, 40);
      1: return 32'(0 - $urandom_range(1, 40));
      2: case ($urandom_range(0, 3))
           0: return 32'h0;
           1: return 32'h8000_0000;
           2: return 32'hFFFF_FFFF;
           default: return 32'h1;
         endcase
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, wait (bounded) for out_valid, capture outputs, consume.
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] r, output logic [2:0] f);
    @(negedge clk);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    r = result;
    f = {eq, lt, ltu};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, result, eq, lt, ltu} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got valid=%b result=%h flags=%b%b%b required all zero",
               out_valid, result, eq, lt, ltu);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: got in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t vecs [16];
    int lat, exp_lat;
    logic [31:0] r;
    logic [2:0] f;
    vecs = '{
      '{5'd0,  32'd7,          32'd5,          32'd12},
      '{5'd7,  32'h8000_0000,  32'h0000_0024,  32'hF800_0000},
      '{5'd16, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE},
      '{5'd17, 32'hFFFF_FFFF,  32'd2,          32'd1},
      '{5'd18, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
      '{5'd20, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
      '{5'd19, 32'd7,          32'd0,          32'hFFFF_FFFF},
      '{5'd21, 32'd7,          32'd0,          32'd7},
      '{5'd18, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
      '{5'd20, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0},
      '{5'd10, 32'd0,          32'd3,          32'd32},
      '{5'd11, 32'd0,          32'd3,          32'd32},
      '{5'd11, 32'd1,          32'd3,          32'd31},
      '{5'd8,  32'hFFFF_FFFF,  32'd1,          32'd1},
      '{5'd9,  32'hFFFF_FFFF,  32'd1,          32'd0},
      '{5'd14, 32'd9,          32'd9,          32'd0}
    };
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].o, vecs[i].x, vecs[i].y, lat, r, f);
      exp_lat = ref_iter(vecs[i].o) ? W + 2 : 1;
      total++;
      if (r !== vecs[i].r) begin
        bad++;
        $display("[TB] FAIL directed_result[%0d] op=%0d: got %h required %h", i, vecs[i].o, r, vecs[i].r);
      end
      total++;
      if (lat !== exp_lat) begin
        bad++;
        $display("[TB] FAIL directed_latency[%0d] op=%0d: got %0d required %0d", i, vecs[i].o, lat, exp_lat);
      end
      total++;
      if (f !== ref_flags(vecs[i].x, vecs[i].y)) begin
        bad++;
        $display("[TB] FAIL directed_flags[%0d]: got %b required %b", i, f, ref_flags(vecs[i].x, vecs[i].y));
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] codes [21];
    logic [4:0] o;
    logic [31:0] x, y, r;
    logic [2:0] f;
    int lat, exp_lat;
    codes = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
              5'd11, 5'd12, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd13, 5'd27};
    for (int i = 0; i < 80; i++) begin
      o = codes[$urandom_range(0, 20)];
      x = pick();
      y = pick();
      run_op(o, x, y, lat, r, f);
      exp_lat = ref_iter(o) ? W + 2 : 1;
      total++;
      if (r !== ref_result(o, x, y)) begin
        bad++;
        $display("[TB] FAIL random_result op=%0d a=%h b=%h: got %h required %h", o, x, y, r, ref_result(o, x, y));
      end
      total++;
      if (f !== ref_flags(x, y)) begin
        bad++;
        $display("[TB] FAIL random_flags a=%h b=%h: got %b required %b", x, y, f, ref_flags(x, y));
      end
      total++;
      if (lat !== exp_lat) begin
        bad++;
        $display("[TB] FAIL random_latency op=%0d: got %0d required %0d", o, lat, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int waited;
    @(negedge clk);
    in_valid = 1'b1; op = 5'd12; a = 32'h0000_F0F0; b = 32'd0; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!out_valid && waited < 50);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_valid_timeout: got out_valid=%b required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (result !== 32'd8 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold[%0d]: got result=%h valid=%b in_ready=%b required 8 1 0",
                 i, result, out_valid, in_ready);
      end
      in_valid = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_not_queued: got valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y;
    x = $urandom;
    y = $urandom;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 5'd4; a = x; b = y;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || result !== (x ^ y) || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_xor: got valid=%b result=%h in_ready=%b required 1 %h 1",
               out_valid, result, in_ready, x ^ y);
    end
    op = 5'd11; a = 32'd1; b = $urandom;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || result !== 32'd31) begin
      bad++;
      $display("[TB] FAIL b2b_clz: got valid=%b result=%h required 1 0000001f", out_valid, result);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    logic seen;
    int lat;
    logic [31:0] r;
    logic [2:0] f;
    @(negedge clk);
    in_valid = 1'b1; op = 5'd18; a = 32'd100; b = 32'd7; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("[TB] FAIL abort_reset: got valid=%b result=%h required 0 0", out_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    total++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_no_pulse: got seen_valid=%b in_ready=%b required 0 1", seen, in_ready);
    end
    run_op(5'd0, 32'd20, 32'd22, lat, r, f);
    total++;
    if (r !== 32'd42 || lat !== 1) begin
      bad++;
      $display("[TB] FAIL abort_next_add: got result=%h latency=%0d required 0000002a 1", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
